// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request per handshake, LATENCY-cycle wait, sized/extended load data.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of silently aligning.
module dmem_responder #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_func3,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy
);
  localparam int WORDS = 2 ** (DM_ADDRESS - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_next;

  logic [3:0]            cnt;
  logic                  cap_we;
  logic [DM_ADDRESS-1:0] cap_addr;
  logic [DATA_W-1:0]     cap_wdata;
  logic [2:0]            cap_func3;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic [DATA_W-1:0]     mem [WORDS];

  logic                  accept, exec;
  logic                  op_we;
  logic [DM_ADDRESS-1:0] op_addr, eff_addr;
  logic [DATA_W-1:0]     op_wdata;
  logic [2:0]            op_func3;
  logic                  legal, misaligned, err;
  logic [DM_ADDRESS-3:0] widx;
  logic [4:0]            shamt;
  logic [DATA_W-1:0]     word, shifted, load_val, wmask, store_word;

  assign accept = (state == IDLE) && req_valid;
  assign exec   = (state_next == RESP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_func3 <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt       <= 4'(LATENCY - 1);
        cap_we    <= req_we;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
        cap_func3 <= req_func3;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (exec) begin
        rdata_q <= (op_we || err) ? '0 : load_val;
        err_q   <= err;
      end else begin
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
    end
  end

  // With LATENCY==1 execution happens on the acceptance edge, so operands bypass the capture registers.
  always_comb begin
    op_we    = (state == IDLE) ? req_we    : cap_we;
    op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
    op_func3 = (state == IDLE) ? req_func3 : cap_func3;
  end

  always_comb begin
    legal = op_we ? (op_func3 inside {3'b000, 3'b001, 3'b010})
                  : (op_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((op_func3[1:0] == 2'b01) && op_addr[0]) ||
                 ((op_func3[1:0] == 2'b10) && (op_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    err = !legal || misaligned;
`else
    err = !legal;
`endif
    case (op_func3[1:0])
      2'b01:   eff_addr = {op_addr[DM_ADDRESS-1:1], 1'b0};
      2'b10:   eff_addr = {op_addr[DM_ADDRESS-1:2], 2'b00};
      default: eff_addr = op_addr;
    endcase
    widx    = eff_addr[DM_ADDRESS-1:2];
    shamt   = {eff_addr[1:0], 3'b000};
    word    = mem[widx];
    shifted = word >> shamt;
    case (op_func3)
      3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_val = {24'd0, shifted[7:0]};
      3'b101:  load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
    case (op_func3[1:0])
      2'b00:   wmask = 32'h0000_00FF << shamt;
      2'b01:   wmask = 32'h0000_FFFF << shamt;
      default: wmask = '1;
    endcase
    store_word = (word & ~wmask) | ((op_wdata << shamt) & wmask);
  end

  // Storage is deliberately not reset; the reset gate only blocks a write racing an abort.
  always_ff @(posedge clk) begin
    if (exec && op_we && !err && !reset) begin
      mem[widx] <= store_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, back-to-back and reset-abort
// sequences, then randomized traffic against a byte-array reference model.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ref_mem [0:511];

  typedef struct {
    bit          we;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl[$];

  dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: byte-addressed memory, size from funct3, alignment by modulo.
  task automatic model(input bit we, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [2:0] f3, output logic [31:0] rd, output bit err);
    int unsigned size, base;
    bit legal;
    logic [7:0] top;
    rd = '0;
    err = 1'b0;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) begin
      err = 1'b1;
      return;
    end
    size = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((addr % size) != 0) begin
      err = 1'b1;
      return;
    end
`endif
    base = addr - (addr % size);
    if (we) begin
      for (int unsigned i = 0; i < size; i++) ref_mem[base + i] = wd[8*i +: 8];
    end else begin
      for (int unsigned i = 0; i < size; i++) rd = rd | (32'(ref_mem[base + i]) << (8 * i));
      top = ref_mem[base + size - 1];
      if (!f3[2] && size < 4 && top[7]) rd = rd | (32'hFFFF_FFFF << (8 * size));
    end
  endtask

  task automatic do_req(input string name, input bit we, input logic [8:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rd, output bit er);
    int k;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_func3 = f3;
    chk({name, ".ready"}, 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!resp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({name, ".latency"}, 32'(k), 32'(LAT));
    rd = resp_rdata;
    er = resp_err;
    @(negedge clk);
    chk({name, ".idle_zero"}, {resp_rdata[29:0], resp_err, resp_valid}, 32'd0);
  endtask

  task automatic add(input bit we, input logic [8:0] a, input logic [31:0] wd, input logic [2:0] f3,
                     input logic [31:0] rd, input bit er);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = wd; v.f3 = f3; v.exp_rd = rd; v.exp_err = er;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, erd, ea, eb;
    bit er, eer, xa, xb, seen;
    int acc[2];
    int nacc, ready_low;
    logic [31:0] rsp[$];

    add(1, 9'h010, 32'hDEADBEEF, 3'b010, 32'h0, 0);
    add(0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF, 0);
    add(0, 9'h011, 32'h0,        3'b100, 32'h000000BE, 0);
    add(0, 9'h012, 32'h0,        3'b001, 32'hFFFFDEAD, 0);
    add(1, 9'h010, 32'h0,        3'b010, 32'h0, 0);
    add(1, 9'h013, 32'h00000080, 3'b000, 32'h0, 0);
    add(0, 9'h013, 32'h0,        3'b000, 32'hFFFFFF80, 0);
    add(0, 9'h013, 32'h0,        3'b100, 32'h00000080, 0);
    add(0, 9'h010, 32'h0,        3'b010, 32'h80000000, 0);
    add(1, 9'h010, 32'h80017FFE, 3'b010, 32'h0, 0);
    add(0, 9'h012, 32'h0,        3'b001, 32'hFFFF8001, 0);
    add(0, 9'h010, 32'h0,        3'b101, 32'h00007FFE, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, 9'h011, 32'h0,        3'b001, 32'h0, 1);
    add(0, 9'h012, 32'h0,        3'b010, 32'h0, 1);
    add(1, 9'h011, 32'h0000AAAA, 3'b001, 32'h0, 1);
    add(0, 9'h010, 32'h0,        3'b010, 32'h80017FFE, 0);
`else
    add(0, 9'h011, 32'h0,        3'b001, 32'h00007FFE, 0);
    add(0, 9'h012, 32'h0,        3'b010, 32'h80017FFE, 0);
    add(1, 9'h011, 32'h0000AAAA, 3'b001, 32'h0, 0);
    add(0, 9'h010, 32'h0,        3'b010, 32'h8001AAAA, 0);
`endif
    add(0, 9'h010, 32'h0,        3'b011, 32'h0, 1);
    add(1, 9'h010, 32'hFFFFFFFF, 3'b011, 32'h0, 1);
    add(0, 9'h010, 32'h0,        3'b110, 32'h0, 1);
    add(1, 9'h012, 32'h00001234, 3'b001, 32'h0, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    add(0, 9'h010, 32'h0,        3'b010, 32'h12347FFE, 0);
`else
    add(0, 9'h010, 32'h0,        3'b010, 32'h1234AAAA, 0);
`endif
    add(1, 9'h020, 32'hCAFEF00D, 3'b010, 32'h0, 0);
    add(0, 9'h020, 32'h0,        3'b010, 32'hCAFEF00D, 0);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err", 32'(resp_err), 32'd0);

    // Directed table
    foreach (tbl[i]) begin
      do_req($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, er);
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, erd, eer);
      chk($sformatf("vec%0d.rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d.err", i), 32'(er), 32'(tbl[i].exp_err));
    end

    // Back-to-back with req_valid held high
    model(0, 9'h010, 32'h0, 3'b010, ea, xa);
    model(0, 9'h020, 32'h0, 3'b010, eb, xb);
    acc = '{0, 0};
    nacc = 0;
    ready_low = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (nacc == 0) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h010; req_func3 = 3'b010;
      end else if (nacc == 1) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 9'h020; req_func3 = 3'b010;
      end else begin
        req_valid = 1'b0;
      end
      if (resp_valid) rsp.push_back(resp_rdata);
      if (nacc == 1 && !req_ready) ready_low++;
      if (req_ready && req_valid && nacc < 2) begin
        acc[nacc] = n;
        nacc++;
      end
    end
    chk("b2b.accepts", 32'(nacc), 32'd2);
    chk("b2b.gap", 32'(acc[1] - acc[0]), 32'(LAT + 1));
    chk("b2b.ready_low", 32'(ready_low), 32'(LAT));
    chk("b2b.nresp", 32'(rsp.size()), 32'd2);
    if (rsp.size() == 2) begin
      chk("b2b.rsp0", rsp[0], ea);
      chk("b2b.rsp1", rsp[1], eb);
    end

    // Reset during WAIT aborts the store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678; req_func3 = 3'b010;
    chk("abort.ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort.busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort.ready_now", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("abort.no_resp", 32'(seen), 32'd0);
    do_req("abort.readback", 0, 9'h020, 32'h0, 3'b010, rd, er);
    chk("abort.word", rd, 32'hCAFEF00D);

    // Fill memory so every model byte is defined, then random traffic
    for (int w = 0; w < 128; w++) begin
      logic [31:0] d;
      d = $urandom;
      model(1, 9'(w * 4), d, 3'b010, erd, eer);
      do_req("fill", 1, 9'(w * 4), d, 3'b010, rd, er);
      chk("fill.err", 32'(er), 32'd0);
    end
    for (int t = 0; t < 400; t++) begin
      bit we;
      logic [8:0] a;
      logic [31:0] d;
      logic [2:0] f3;
      we = 1'($urandom_range(0, 1));
      a  = 9'($urandom_range(0, 511));
      d  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      model(we, a, d, f3, erd, eer);
      do_req($sformatf("rnd%0d", t), we, a, d, f3, rd, er);
      chk($sformatf("rnd%0d.rdata", t), rd, erd);
      chk($sformatf("rnd%0d.err", t), 32'(er), 32'(eer));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
